// File: rtl/qsys_system_nios2_qsys_mul_seq.sv
// Sequential Nios II multiply unit that drives an external 32x32 low-product cell.
// MULX* high-word ops (four 16-bit passes plus sign correction) exist only with NIOS2_MUL_SEQ_MULX_EN.
module qsys_system_nios2_qsys_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] A_mul_src1,
    output logic [31:0] A_mul_src2,
    input  logic [31:0] A_mul_cell_result
);
    typedef enum logic [2:0] {IDLE, ISSUE, ACC, CORR, DONE} state_t;

    state_t      state;
    logic [31:0] src1_reg;
    logic [31:0] src2_reg;
    logic [1:0]  pass_idx;
    // s1 tracks what sits on the cell operand lines, s2 what the cell result currently holds
    logic        s1_valid;
    logic [1:0]  s1_idx;
    logic        s2_valid;
    logic [1:0]  s2_idx;
    logic        accept;
    logic        mulx_req;
    logic        mulx_reg;
    logic [1:0]  last_idx;

    assign accept   = req_valid & req_ready;
    assign last_idx = mulx_reg ? 2'd3 : 2'd0;

    // Operand pair for a pass: full words for MUL, zero-extended halves for MULX*
    function automatic logic [63:0] pass_ops(input logic mulx, input logic [1:0] idx,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ops;
        if (!mulx) begin
            ops = {a, b};
        end else begin
            case (idx)
                2'd0:    ops = {16'd0, a[15:0],  16'd0, b[15:0]};
                2'd1:    ops = {16'd0, a[15:0],  16'd0, b[31:16]};
                2'd2:    ops = {16'd0, a[31:16], 16'd0, b[15:0]};
                default: ops = {16'd0, a[31:16], 16'd0, b[31:16]};
            endcase
        end
        return ops;
    endfunction

`ifdef NIOS2_MUL_SEQ_MULX_EN
    logic [1:0]  op_reg;
    logic [63:0] acc;
    logic [63:0] weighted;
    logic [31:0] hi_corr;

    assign mulx_req = (req_op != 2'b00);
    assign mulx_reg = (op_reg != 2'b00);

    always_comb begin
        case (s2_idx)
            2'd0:    weighted = {32'd0, A_mul_cell_result};
            2'd3:    weighted = {A_mul_cell_result, 32'd0};
            default: weighted = {16'd0, A_mul_cell_result, 16'd0};
        endcase
    end

    // Signed high word from the unsigned product: subtract the other operand per negative signed input
    always_comb begin
        hi_corr = acc[63:32];
        if (op_reg[1] && src1_reg[31])
            hi_corr = hi_corr - src2_reg;
        if ((op_reg == 2'b11) && src2_reg[31])
            hi_corr = hi_corr - src1_reg;
    end
`else
    logic unused_op;

    assign unused_op = ^req_op;
    assign mulx_req  = 1'b0;
    assign mulx_reg  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'd0;
            A_mul_src1 <= 32'd0;
            A_mul_src2 <= 32'd0;
            src1_reg   <= 32'd0;
            src2_reg   <= 32'd0;
            pass_idx   <= 2'd0;
            s1_valid   <= 1'b0;
            s1_idx     <= 2'd0;
            s2_valid   <= 1'b0;
            s2_idx     <= 2'd0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
            op_reg     <= 2'd0;
            acc        <= 64'd0;
`endif
        end else begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
`ifdef NIOS2_MUL_SEQ_MULX_EN
            if (s2_valid && mulx_reg)
                acc <= acc + weighted;
`endif
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        src1_reg   <= req_src1;
                        src2_reg   <= req_src2;
                        pass_idx   <= 2'd0;
                        {A_mul_src1, A_mul_src2} <= pass_ops(mulx_req, 2'd0, req_src1, req_src2);
                        s1_valid   <= 1'b1;
                        s1_idx     <= 2'd0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
                        op_reg     <= req_op;
                        acc        <= 64'd0;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (pass_idx != last_idx) begin
                        pass_idx <= pass_idx + 2'd1;
                        {A_mul_src1, A_mul_src2} <= pass_ops(mulx_reg, pass_idx + 2'd1, src1_reg, src2_reg);
                        s1_valid <= 1'b1;
                        s1_idx   <= pass_idx + 2'd1;
                    end else begin
                        A_mul_src1 <= 32'd0;
                        A_mul_src2 <= 32'd0;
                        s1_valid   <= 1'b0;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (s2_valid && (s2_idx == last_idx)) begin
                        if (mulx_reg) begin
                            state <= CORR;
                        end else begin
                            rsp_result <= A_mul_cell_result;
                            rsp_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                CORR: begin
`ifdef NIOS2_MUL_SEQ_MULX_EN
                    rsp_result <= hi_corr;
`endif
                    rsp_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qsys_system_nios2_qsys_mul_seq.sv
// Directed bench for the sequential multiplier; models the one-cycle multiplier cell.
module tb_qsys_system_nios2_qsys_mul_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_src1 = 32'd0;
    logic [31:0] req_src2 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [31:0] A_mul_src1;
    logic [31:0] A_mul_src2;
    logic [31:0] A_mul_cell_result = 32'd0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    qsys_system_nios2_qsys_mul_seq dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_src1          (req_src1),
        .req_src2          (req_src2),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_result        (rsp_result),
        .A_mul_src1        (A_mul_src1),
        .A_mul_src2        (A_mul_src2),
        .A_mul_cell_result (A_mul_cell_result)
    );

    always #5 clk = ~clk;

    // Multiplier cell: low 32 bits of the product, registered one clock after operands
    always @(posedge clk) A_mul_cell_result <= 32'(A_mul_src1 * A_mul_src2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int          n;
        int          lat;
        logic [31:0] exp_res;
        logic [31:0] exp_a0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
        lat     = (v.op == 2'b00) ? 2 : 6;
        exp_res = (v.op == 2'b00) ? v.exp_lo : v.exp_hi;
        exp_a0  = (v.op == 2'b00) ? v.a : {16'd0, v.a[15:0]};
`else
        lat     = 2;
        exp_res = v.exp_lo;
        exp_a0  = v.a;
`endif
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = v.op;
        req_src1  = v.a;
        req_src2  = v.b;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
        check("cell_src1_first_pass", A_mul_src1, exp_a0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("rsp_result", rsp_result, exp_res);
        check("cell_src_idle_in_done", A_mul_src1 | A_mul_src2, 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_result", rsp_result, exp_res);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_take", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_after_take", {31'd0, req_ready}, 32'd1);
        $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", v.op, v.a, v.b, exp_res, lat);
    endtask

    initial begin
        int n;
        vecs[0]  = '{2'b00, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 32'h0000_0000, 0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 0};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0};
        vecs[5]  = '{2'b11, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0};
        vecs[6]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 0};
        vecs[7]  = '{2'b01, 32'hFFFF_0000, 32'h0002_0000, 32'h0000_0000, 32'h0001_FFFE, 0};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFE, 0};
        vecs[9]  = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
        vecs[10] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 32'h0000_0000, 5};
        vecs[11] = '{2'b01, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 32'h0000_0000, 5};

        // Reset state
        #2;
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_cell_src", A_mul_src1 | A_mul_src2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_first_edge", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Reset during pass 2 of a MULXUU discards the operation
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_src1  = 32'hFFFF_FFFF;
        req_src2  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midop_reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("midop_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midop_reset_rsp_result", rsp_result, 32'd0);
        check("midop_reset_cell_src1", A_mul_src1, 32'd0);
        check("midop_reset_cell_src2", A_mul_src2, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_midop_reset", {31'd0, req_ready}, 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n++;
        end
        check("no_rsp_after_reset", n, 0);
        run_op('{2'b00, 32'd3, 32'd5, 32'h0000_000F, 32'h0000_0000, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
